// File: rtl/pwm_gen.sv
// pwm_gen: fixed-on / clamped-off PWM timing stage for the PID loop.
// Drives the gate for on_len cycles, then holds it low for off_len cycles,
// and repeats. It pulses pwm_en when each off interval starts, and takes
// off_div/total_time into its shadows only at a period boundary while
// pwm_rdy is high.
// Optional feature macro: PWM_SOFT_START_EN. When it is defined, on_len ramps
// from 1 up to ON_TIME after every IDLE->ON entry.
module pwm_gen #(
  parameter int CNT_WIDTH = 18,
  parameter int ON_TIME   = 40,
  parameter int MIN_OFF   = 2,
  parameter int START_OFF = 100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [CNT_WIDTH-1:0] off_div,
  input  logic [CNT_WIDTH-1:0] total_time,
  input  logic                 pwm_rdy,
  input  logic                 ocp,
  output logic                 gate,
  output logic                 pwm_en,
  output logic [7:0]           ocp_count
);

  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

  localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] ON_W     = CNT_WIDTH'(ON_TIME);
  localparam logic [CNT_WIDTH-1:0] MIN_W    = CNT_WIDTH'(MIN_OFF);
  localparam logic [CNT_WIDTH:0]   ON_EXT   = (CNT_WIDTH+1)'(ON_TIME);
  localparam logic [CNT_WIDTH:0]   MIN_EXT  = (CNT_WIDTH+1)'(MIN_OFF);

  state_t               state, next_state;
  logic [CNT_WIDTH-1:0] cnt, cnt_next;
  logic [CNT_WIDTH-1:0] off_sh, tot_sh;
  logic [CNT_WIDTH-1:0] off_base, off_len, on_len;
  logic [CNT_WIDTH:0]   off_sum, tot_ext;
  logic                 load_sh, ocp_evt, on_end;

  // Off-length clamp applied to the raw shadow values.
  // The sum is widened by one bit, so ON_TIME+off_len cannot wrap.
  // NOTE: every combinational output is given a default first, so no path can infer a latch.
  always_comb begin
    off_base = off_sh;
    if (off_sh[CNT_WIDTH-1] || (off_sh < MIN_W)) off_base = MIN_W;
    off_sum = ON_EXT + {1'b0, off_base};
    tot_ext = {1'b0, tot_sh};
    off_len = off_base;
    if (!off_sh[CNT_WIDTH-1] && (tot_ext >= ON_EXT + MIN_EXT) && (off_sum > tot_ext))
      off_len = CNT_WIDTH'(tot_ext - ON_EXT);
  end

  // Next-state, counter and event decode. Dropping enable takes priority over OCP.
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    load_sh    = 1'b0;
    ocp_evt    = 1'b0;
    on_end     = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) begin
          next_state = ON;
          cnt_next   = '0;
          load_sh    = pwm_rdy;
        end
      end
      ON: begin
        if (!enable) begin
          next_state = IDLE;
          cnt_next   = '0;
        end else if (ocp) begin
          next_state = OFF;
          cnt_next   = '0;
          ocp_evt    = 1'b1;
        end else if (cnt == on_len - ONE) begin
          next_state = OFF;
          cnt_next   = '0;
          on_end     = 1'b1;
        end else begin
          cnt_next = cnt + ONE;
        end
      end
      OFF: begin
        if (!enable) begin
          next_state = IDLE;
          cnt_next   = '0;
        end else if (cnt == off_len - ONE) begin
          next_state = ON;
          cnt_next   = '0;
          load_sh    = pwm_rdy;
        end else begin
          cnt_next = cnt + ONE;
        end
      end
      default: begin
        next_state = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // State, counter and registered outputs.
  // The gate copies the next state, so it is high for exactly on_len cycles per period.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      gate   <= 1'b0;
      pwm_en <= 1'b0;
    end else begin
      state  <= next_state;
      cnt    <= cnt_next;
      gate   <= (next_state == ON);
      pwm_en <= (state == ON) && (next_state == OFF);
    end
  end

  // Shadow registers for off_div/total_time; loaded at period boundaries only.
  // NOTE: the shadows get a real reset value, because the first period uses them before any load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_sh <= CNT_WIDTH'(START_OFF);
      tot_sh <= CNT_WIDTH'(ON_TIME + START_OFF);
    end else if (load_sh) begin
      off_sh <= off_div;
      tot_sh <= total_time;
    end
  end

  // Saturating count of periods cut short by over-current.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            ocp_count <= 8'd0;
    else if (ocp_evt && ocp_count != 8'hFF) ocp_count <= ocp_count + 8'd1;
  end

`ifdef PWM_SOFT_START_EN
  // Soft start: restart at 1 on every IDLE->ON entry.
  // Grow by one after each period that ended normally; an OCP period leaves it unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 on_len <= ONE;
    else if (state == IDLE && enable)        on_len <= ONE;
    else if (on_end && on_len < ON_W)        on_len <= on_len + ONE;
  end
`else
  // Without soft start the on-time is fixed.
  assign on_len = ON_W;
  logic unused_on_end;
  assign unused_on_end = on_end;
`endif

endmodule

// File: tb/tb_pwm_gen.sv
// Directed self-checking bench for pwm_gen.
// Measures the gate high/low run lengths and the pwm_en pulses in each period.
// The PWM_SOFT_START_EN build also checks the on-time ramp.
module tb_pwm_gen;

  localparam int CW = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [CW-1:0] off_div, total_time;
  logic          pwm_rdy, ocp;
  logic          gate, pwm_en;
  logic [7:0]    ocp_count;

  int checks   = 0;
  int failures = 0;
  int h, l, pe;

  pwm_gen #(.CNT_WIDTH(CW), .ON_TIME(40), .MIN_OFF(2), .START_OFF(100)) dut (
    .clk(clk), .rst(rst), .enable(enable), .off_div(off_div),
    .total_time(total_time), .pwm_rdy(pwm_rdy), .ocp(ocp),
    .gate(gate), .pwm_en(pwm_en), .ocp_count(ocp_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Measure one period, sampling on falling edges.
  // The task first waits for the gate to be high.
  // It returns at the falling edge where the next high phase begins.
  // ocp_at >= 0 raises ocp during ON cycle number ocp_at (counting from 0).
  task automatic run_period(input int ocp_at, output int hi, output int lo, output int pen);
    int g = 0;
    while (gate !== 1'b1 && g < 2000) begin g++; @(negedge clk); end
    hi = 0; lo = 0; pen = 0;
    while (gate === 1'b1 && hi < 2000) begin
      hi++;
      ocp = (hi == ocp_at + 1);
      if (pwm_en === 1'b1) pen++;
      @(negedge clk);
    end
    ocp = 1'b0;
    while (gate === 1'b0 && lo < 2000) begin
      lo++;
      if (pwm_en === 1'b1) pen++;
      @(negedge clk);
    end
  endtask

  // Load new controller values at the start of a high phase.
  // The first period shown still has the old off length; the second one is checked.
  task automatic check_off(input string tag, input int od, input int tt, input int exp);
    off_div = CW'(od); total_time = CW'(tt);
    run_period(-1, h, l, pe);
    run_period(-1, h, l, pe);
    check(tag, l, exp);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; off_div = CW'(100); total_time = CW'(400);
    pwm_rdy = 1'b1; ocp = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_gate", int'(gate), 0);
    check("rst_pwm_en", int'(pwm_en), 0);
    check("rst_ocp_count", int'(ocp_count), 0);

    rst = 1'b0;
    @(negedge clk);
    check("idle_gate", int'(gate), 0);
    enable = 1'b1;

`ifdef PWM_SOFT_START_EN
    for (int k = 1; k <= 41; k++) begin
      run_period(-1, h, l, pe);
      check($sformatf("soft_high_%0d", k), h, (k > 40) ? 40 : k);
    end
`endif

    // Basic 40 high / 100 low timing with one pwm_en pulse per period.
    for (int k = 0; k < 2; k++) begin
      run_period(-1, h, l, pe);
      check("t1_high", h, 40);
      check("t1_low", l, 100);
      check("t1_pwm_en_pulses", pe, 1);
    end

    // Off-length clamp cases.
    check_off("t2_off_zero", 0, 400, 2);
    check_off("t2_clamp_total", 500, 400, 360);
    check_off("t2_total_zero", 150, 0, 150);
    check_off("t2_msb_set", 32'h20000, 400, 2);
    check_off("t2_total_small", 100, 41, 100);
    check_off("t2_total_edge", 2, 42, 2);

    // Shadows hold while pwm_rdy is low and reload once it returns.
    check_off("t3_settle", 100, 400, 100);
    pwm_rdy = 1'b0; off_div = CW'(200);
    run_period(-1, h, l, pe);
    run_period(-1, h, l, pe);
    check("t3_hold_100", l, 100);
    pwm_rdy = 1'b1;
    run_period(-1, h, l, pe);
    run_period(-1, h, l, pe);
    check("t3_reload_200", l, 200);

    // OCP truncation, OCP coinciding with the end of the on-time, and saturation.
    off_div = CW'(100);
    run_period(-1, h, l, pe);
    run_period(10, h, l, pe);
    check("t4_ocp_high", h, 11);
    check("t4_ocp_pulses", pe, 1);
    check("t4_ocp_low", l, 100);
    check("t4_ocp_count1", int'(ocp_count), 1);
    run_period(39, h, l, pe);
    check("t4_ocp_end_high", h, 40);
    check("t4_ocp_end_pulses", pe, 1);
    check("t4_ocp_count2", int'(ocp_count), 2);
    off_div = CW'(2);
    for (int k = 0; k < 260; k++) run_period(0, h, l, pe);
    check("t4_ocp_sat_high", h, 1);
    check("t4_ocp_sat", int'(ocp_count), 255);

    // Dropping enable during ON ends the period at once with no pwm_en pulse.
    // OCP is ignored while idle.
    off_div = CW'(100);
    run_period(-1, h, l, pe);
    run_period(-1, h, l, pe);
    repeat (5) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("t5_en_low_gate", int'(gate), 0);
    check("t5_en_low_pwm_en", int'(pwm_en), 0);
    ocp = 1'b1;
    pe = 0; h = 0;
    repeat (10) begin
      @(negedge clk);
      if (pwm_en === 1'b1) pe++;
      if (gate === 1'b1) h++;
    end
    ocp = 1'b0;
    check("t5_idle_pwm_en", pe, 0);
    check("t5_idle_gate", h, 0);
    check("t5_idle_ocp_ignored", int'(ocp_count), 255);

    // Reset in the middle of ON clears the outputs asynchronously.
    enable = 1'b1;
    @(negedge clk);
    check("t5_restart_gate", int'(gate), 1);
    rst = 1'b1;
    #1;
    check("t5_async_gate", int'(gate), 0);
    check("t5_async_pwm_en", int'(pwm_en), 0);
    check("t5_async_ocp_count", int'(ocp_count), 0);
    @(negedge clk);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
